// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 scancode receiver:
//                receive FSM state encoding, prefix byte values and a frame
//                parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Receive FSM states; each advances only on a filtered clock fall.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  // Scancode prefix bytes.
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic ps2_frame_odd(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_scancode_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_rx_if
//  Description : Bundle of the PS/2 pins and the scancode output bus.
//    ps2_clock, ps2_data : raw PS/2 pins (asynchronous to the system clock)
//    scancode            : last good byte, held until the next good byte
//    valid               : one-cycle pulse, scancode updated
//    is_break            : scancode was preceded by 0xF0
//    is_extended         : 0xE0 seen since the last non-prefix byte
//    parity_err          : one-cycle pulse, frame dropped on bad parity
//    frame_err           : one-cycle pulse, frame dropped on bad stop / timeout
//    modport master : device / stimulus side (drives the pins)
//    modport slave  : receiver side (drives the scancode bus)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scancode_rx_if;

  logic       ps2_clock;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       valid;
  logic       is_break;
  logic       is_extended;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output ps2_clock, ps2_data,
    input  scancode, valid, is_break, is_extended, parity_err, frame_err
  );

  modport slave (
    input  ps2_clock, ps2_data,
    output scancode, valid, is_break, is_extended, parity_err, frame_err
  );

endinterface : ps2_scancode_rx_if
`default_nettype wire

// File: rtl/ps2_input_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_input_filter
//  Description : Two-flop synchroniser followed by a debounce filter. The
//                filtered level only changes after FILTER_LEN consecutive
//                synchronised samples disagree with it.
//    clk_i   : system clock
//    rst_ni  : asynchronous active-low reset (filtered level resets high)
//    pin_i   : raw asynchronous pin
//    level_o : filtered level
//    fall_o  : one-cycle pulse in the cycle the filtered level goes 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             w_flip;

  // Idle PS/2 lines are high, so every stage resets to 1 to avoid a
  // spurious falling edge coming out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      meta_q  <= pin_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Run-length counter of samples disagreeing with the filtered level; any
  // agreeing sample restarts the run.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    w_flip  = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        w_flip  = 1'b1;
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  // Asserted in the same cycle the level is about to drop, so the caller can
  // sample data alongside it.
  assign fall_o  = w_flip & level_q;

endmodule : ps2_input_filter
`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_rx
//  Description : PS/2 device-to-host receiver. Conditions the raw pins,
//                deframes 11-bit frames (start, 8 data LSB first, odd parity,
//                stop), and emits one valid pulse per good byte with
//                break/extended prefix annotation. Bad frames raise
//                parity_err or frame_err instead.
//    clk_in  : system clock, single domain
//    reset_n : asynchronous active-low reset
//    bus     : pins in, scancode/valid/flags/errors out (slave modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk_in,
  input  logic              reset_n,
  ps2_scancode_rx_if.slave  bus
);

  localparam int               TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic w_clk_level;
  logic w_fall;
  logic data_meta_q;
  logic data_sync_q;
  logic clk_level_q;
  logic w_clk_edge;

  ps2_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk_i   (clk_in),
    .rst_ni  (reset_n),
    .pin_i   (bus.ps2_clock),
    .level_o (w_clk_level),
    .fall_o  (w_fall)
  );

  // Data is only sampled on a debounced clock fall, so it needs
  // synchronising but no filtering.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      clk_level_q <= 1'b1;
    end else begin
      data_meta_q <= bus.ps2_data;
      data_sync_q <= data_meta_q;
      clk_level_q <= w_clk_level;
    end
  end

  // Any filtered clock transition, seen one cycle after the level changes.
  assign w_clk_edge = (w_clk_level != clk_level_q);

  // --------------------------------------------------------------------------
  // Receive state
  // --------------------------------------------------------------------------
  ps2_rx_state_t    state_q,      state_d;
  logic [2:0]       bitcnt_q,     bitcnt_d;
  logic [7:0]       shift_q,      shift_d;
  logic             parity_q,     parity_d;
  logic [TMO_W-1:0] tmo_q,        tmo_d;
  logic [7:0]       scancode_q,   scancode_d;
  logic             is_break_q,   is_break_d;
  logic             is_ext_q,     is_ext_d;
  logic             brk_pend_q,   brk_pend_d;
  logic             ext_pend_q,   ext_pend_d;
  logic             valid_q,      valid_d;
  logic             perr_q,       perr_d;
  logic             ferr_q,       ferr_d;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      scancode_q <= '0;
      is_break_q <= 1'b0;
      is_ext_q   <= 1'b0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      scancode_q <= scancode_d;
      is_break_q <= is_break_d;
      is_ext_q   <= is_ext_d;
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Idle-time counter. The fall pulse also clears it because the edge signal
  // lags by a cycle: without this, a saturated count left over from IDLE
  // would trip a timeout right after a start bit.
  always_comb begin
    tmo_d = tmo_q;
    if (w_fall || w_clk_edge) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    scancode_d = scancode_q;
    is_break_d = is_break_q;
    is_ext_d   = is_ext_q;
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    if (w_fall) begin
      case (state_q)
        IDLE: begin
          // A high line at a fall is not a start bit; ignore it silently.
          if (!data_sync_q) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {data_sync_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = data_sync_q;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (ps2_frame_odd(shift_q, parity_q) && data_sync_q) begin
            valid_d    = 1'b1;
            scancode_d = shift_q;
            // Flags describe the prefixes that came before this byte.
            is_break_d = brk_pend_q;
            is_ext_d   = ext_pend_q;
            if (shift_q == PS2_BREAK) begin
              brk_pend_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
              ext_pend_d = 1'b1;
            end else begin
              brk_pend_d = 1'b0;
              ext_pend_d = 1'b0;
            end
          end else begin
            // Bad parity is reported even when the stop bit is also bad.
            if (!ps2_frame_odd(shift_q, parity_q)) begin
              perr_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q != IDLE) && (tmo_q == TMO_MAX)) begin
      state_d    = IDLE;
      ferr_d     = 1'b1;
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end
  end

  assign bus.scancode    = scancode_q;
  assign bus.valid       = valid_q;
  assign bus.is_break    = is_break_q;
  assign bus.is_extended = is_ext_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_err   = ferr_q;

endmodule : ps2_scancode_rx
`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scancode_rx
//  Description : Self-checking bench for ps2_scancode_rx. Expected output
//                pulses are queued as frames are sent and compared as the
//                receiver produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 2000;

  logic clk;
  logic reset_n;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   last_rise_cyc;
  int   last_pulse_cyc;

  // Packed expectation: {valid, parity_err, frame_err, scancode, brk, ext}
  logic [12:0] exp_q[$];

  // Reference model of the prefix tracking and held outputs.
  logic [7:0] m_code;
  logic       m_brk;
  logic       m_ext;
  logic       m_pend_brk;
  logic       m_pend_ext;

  ps2_scancode_rx_if bus();

  ps2_scancode_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_in  (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [12:0] got;
    logic [12:0] exp;
    if (reset_n && (bus.valid || bus.parity_err || bus.frame_err)) begin
      got = {bus.valid, bus.parity_err, bus.frame_err, bus.scancode,
             bus.is_break, bus.is_extended};
      last_pulse_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got %h (v/pe/fe/code/brk/ext), expected none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL pulse: got %h, expected %h (v/pe/fe/code/brk/ext)", got, exp);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic model_reset();
    m_code     = 8'h00;
    m_brk      = 1'b0;
    m_ext      = 1'b0;
    m_pend_brk = 1'b0;
    m_pend_ext = 1'b0;
  endtask

  task automatic push_good(input logic [7:0] b);
    exp_q.push_back({3'b100, b, m_pend_brk, m_pend_ext});
    m_code = b;
    m_brk  = m_pend_brk;
    m_ext  = m_pend_ext;
    if (b == 8'hF0)      m_pend_brk = 1'b1;
    else if (b == 8'hE0) m_pend_ext = 1'b1;
    else begin
      m_pend_brk = 1'b0;
      m_pend_ext = 1'b0;
    end
  endtask

  task automatic push_err(input logic is_parity);
    exp_q.push_back({1'b0, is_parity, ~is_parity, m_code, m_brk, m_ext});
    m_pend_brk = 1'b0;
    m_pend_ext = 1'b0;
  endtask

  // One PS/2 bit is 400 clk: 100 high, 200 low (fall mid-bit), 100 high.
  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_bit, input int nbits,
                            input int glitch_bit);
    logic [10:0] fr;
    fr = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      if (glitch_bit == i) begin
        wait_clks(50);
        bus.ps2_clock = 1'b0;
        wait_clks(2);
        bus.ps2_clock = 1'b1;
        wait_clks(48);
      end else begin
        wait_clks(100);
      end
      bus.ps2_clock = 1'b0;
      if (glitch_bit == i) begin
        wait_clks(100);
        bus.ps2_clock = 1'b1;
        wait_clks(2);
        bus.ps2_clock = 1'b0;
        wait_clks(98);
      end else begin
        wait_clks(200);
      end
      bus.ps2_clock = 1'b1;
      last_rise_cyc = cyc;
      wait_clks(100);
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.ps2_clock = 1'b1;
    bus.ps2_data  = 1'b1;
    model_reset();
    wait_clks(5);
    reset_n = 1'b1;
    wait_clks(20);
    vectors++;
    if (bus.scancode !== 8'h00) begin
      miscompares++; $display("FAIL reset_scancode: got %h, expected 00", bus.scancode);
    end
    vectors++;
    if (bus.valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b, expected 0", bus.valid);
    end
    vectors++;
    if ({bus.is_break, bus.is_extended} !== 2'b00) begin
      miscompares++; $display("FAIL reset_flags: got %b%b, expected 00", bus.is_break, bus.is_extended);
    end
    vectors++;
    if ({bus.parity_err, bus.frame_err} !== 2'b00) begin
      miscompares++; $display("FAIL reset_errs: got %b%b, expected 00", bus.parity_err, bus.frame_err);
    end
  endtask

  task automatic test_single();
    push_good(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    wait_drain(100);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL single_missing: got %0d outstanding, expected 0", exp_q.size());
    end
    vectors++;
    if (bus.scancode !== 8'h1C) begin
      miscompares++; $display("FAIL single_hold: got %h, expected 1c", bus.scancode);
    end
  endtask

  task automatic test_break();
    logic [7:0] seq [3] = '{8'hF0, 8'h1C, 8'h1D};
    foreach (seq[i]) begin
      push_good(seq[i]);
      send_frame(seq[i], 1'b0, 1'b1, 11, -1);
    end
    wait_drain(100);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL break_missing: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [3] = '{8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) begin
      push_good(seq[i]);
      send_frame(seq[i], 1'b0, 1'b1, 11, -1);
    end
    wait_drain(100);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL ext_missing: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_errors();
    push_err(1'b1);
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    push_err(1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
    push_err(1'b1);
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
    wait_drain(100);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL err_missing: got %0d outstanding, expected 0", exp_q.size());
    end
    vectors++;
    if (bus.scancode !== m_code) begin
      miscompares++; $display("FAIL err_scancode_held: got %h, expected %h", bus.scancode, m_code);
    end
  endtask

  task automatic test_timeout();
    int delta;
    push_good(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    push_err(1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 5, -1);
    wait_drain(TIMEOUT_CYCLES + 1000);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL timeout_missing: got %0d outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    delta = last_pulse_cyc - last_rise_cyc;
    vectors++;
    if (delta < TIMEOUT_CYCLES - 50 || delta > TIMEOUT_CYCLES + 100) begin
      miscompares++; $display("FAIL timeout_latency: got %0d cycles, expected about %0d", delta, TIMEOUT_CYCLES);
    end
    push_good(8'h29);
    send_frame(8'h29, 1'b0, 1'b1, 11, -1);
    wait_drain(100);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL timeout_recover: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_glitch();
    push_good(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 11, 2);
    wait_drain(100);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL glitch_missing: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h33, 1'b0, 1'b1, 5, -1);
    reset_n = 1'b0;
    wait_clks(3);
    vectors++;
    if ({bus.scancode, bus.valid, bus.is_break, bus.is_extended,
         bus.parity_err, bus.frame_err} !== 13'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got code=%h v=%b b=%b e=%b pe=%b fe=%b, expected all 0",
               bus.scancode, bus.valid, bus.is_break, bus.is_extended,
               bus.parity_err, bus.frame_err);
    end
    model_reset();
    reset_n = 1'b1;
    wait_clks(50);
    push_good(8'h29);
    send_frame(8'h29, 1'b0, 1'b1, 11, -1);
    wait_drain(100);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL midreset_recover: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hF0 || b == 8'hE0) b = b ^ 8'h01;
      push_good(b);
      send_frame(b, 1'b0, 1'b1, 11, -1);
    end
    wait_drain(100);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL b2b_missing: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    cyc            = 0;
    vectors        = 0;
    miscompares    = 0;
    last_rise_cyc  = 0;
    last_pulse_cyc = 0;
    test_reset();
    test_single();
    test_break();
    test_extended();
    test_errors();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    wait_clks(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end

endmodule : tb_ps2_scancode_rx
`default_nettype wire
